// File: rtl/nibble_serial_adder_if.sv
// +----------------------------------------------------------------------+
// | nibble_serial_adder_if                                               |
// | Operand/result handshake bundle for nibble_serial_adder.             |
// | Optional ovf signal present when NSA_OVERFLOW_EN is defined.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NSA_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout,
`ifdef NSA_OVERFLOW_EN
    input  ovf,
`endif
    input  busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout,
`ifdef NSA_OVERFLOW_EN
    output ovf,
`endif
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// +----------------------------------------------------------------------+
// | nibble_serial_adder                                                  |
// | Multi-cycle adder: one 4-bit carry-select slice per ADD cycle.       |
// | Optional two's-complement overflow output: define NSA_OVERFLOW_EN.   |
// | WIDTH must be a multiple of 4 and at least 8.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
`ifdef NSA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [3:0] a_nib, b_nib, s_nib;
  logic [4:0] s0, s1;
  logic       c_sel;

  // Both slice sums are formed up front; the registered carry only picks one.
  always_comb begin
    a_nib          = a_q[{idx_q, 2'b00} +: 4];
    b_nib          = b_q[{idx_q, 2'b00} +: 4];
    s0             = {1'b0, a_nib} + {1'b0, b_nib};
    s1             = s0 + 5'd1;
    {c_sel, s_nib} = carry_q ? s1 : s0;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef NSA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[{idx_q, 2'b00} +: 4] = s_nib;
        carry_d                    = c_sel;
        idx_d                      = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = c_sel;
`ifdef NSA_OVERFLOW_EN
          // Carry into the MSB is recovered from the MSB's own sum bit.
          ovf_d   = c_sel ^ (a_nib[3] ^ b_nib[3] ^ s_nib[3]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ADD);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef NSA_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized self-checking bench for nibble_serial_adder (WIDTH=16).
`default_nettype none

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge: waits for the result and checks it.
  task automatic finish_op(input string tag, input logic [15:0] es, input logic ec,
                           input logic eo, input bit hs);
    int c;
    chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    c = 0;
    do begin
      tick();
      c++;
    end while (!bus.out_valid && c < 20);
    chk({tag, " latency"}, c, NIB);
    chk({tag, " sum"}, {16'd0, bus.sum}, {16'd0, es});
    chk({tag, " cout"}, {31'd0, bus.cout}, {31'd0, ec});
`ifdef NSA_OVERFLOW_EN
    chk({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
`endif
    if (hs) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, " out_valid fall"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, " in_ready back"}, {31'd0, bus.in_ready}, 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] es, input logic ec,
                        input logic eo, input bit hs);
    chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    finish_op(tag, es, ec, eo, hs);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] na, nb, ca, cb, es;
    logic        nc, cc, ec, eo;
    int          c;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst sum", {16'd0, bus.sum}, 32'd0);
    chk("rst cout", {31'd0, bus.cout}, 32'd0);
`ifdef NSA_OVERFLOW_EN
    chk("rst ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // Directed vectors
    run_op("v1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    run_op("vffff1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("vffffc", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("v7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_op("v8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of ADD after two slice steps
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst sum", {16'd0, bus.sum}, 32'd0);
    chk("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst cout", {31'd0, bus.cout}, 32'd0);
`ifdef NSA_OVERFLOW_EN
    chk("midrst ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    #2;
    rst = 1'b0;
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);

    // Back-pressure in DONE with a new operand set waiting
    run_op("bp", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    bus.a = 16'hAAAA; bus.b = 16'h1111; bus.cin = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp hold sum", {16'd0, bus.sum}, 32'h5555);
      chk("bp hold out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp hold in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp idle in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp idle out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp idle sum kept", {16'd0, bus.sum}, 32'h5555);
    tick();
    bus.in_valid = 1'b0;
    chk("bp accepted", {31'd0, bus.in_ready}, 32'd0);
    finish_op("bp next", 16'hBBBC, 1'b0, 1'b0, 1'b1);

    // Back-to-back random operations, next operands driven during ADD/DONE
    bus.out_ready = 1'b1;
    na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom);
    bus.a = na; bus.b = nb; bus.cin = nc; bus.in_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      chk("b2b in_ready", {31'd0, bus.in_ready}, 32'd1);
      ca = na; cb = nb; cc = nc;
      {ec, es} = {1'b0, ca} + {1'b0, cb} + {16'd0, cc};
      eo = (ca[15] == cb[15]) && (es[15] != ca[15]);
      tick();
      na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom);
      bus.a = na; bus.b = nb; bus.cin = nc;
      c = 0;
      do begin
        tick();
        c++;
      end while (!bus.out_valid && c < 20);
      chk("b2b latency", c, NIB);
      chk("b2b sum", {16'd0, bus.sum}, {16'd0, es});
      chk("b2b cout", {31'd0, bus.cout}, {31'd0, ec});
`ifdef NSA_OVERFLOW_EN
      chk("b2b ovf", {31'd0, bus.ovf}, {31'd0, eo});
`endif
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
